countdown_core: RTL and testbench
=================================

Name: countdown_core

Overview:
- Upstream stage of the 4-digit scanned display: holds an MM:SS countdown in BCD and drives the four digit inputs of the display scanner.
- Digit 0 is seconds units, digit 1 seconds tens, digit 2 minutes units, digit 3 minutes tens.
- Counts down once per 1 Hz enable pulse under start/pause control.
- Flags expiry and raises a bounded alarm.

Parameters:
- DEFAULT_VALUE, 16'h0100, BCD MM:SS value loaded at reset (01:00).
- ALARM_TICKS, 5, number of tick_1hz pulses the alarm stays high after expiry; range 1..255.

Ports:
- sys_clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick_1hz  input  1  single-cycle enable, one pulse per second.
- start_pause  input  1  single-cycle debounced button pulse.
- load  input  1  single-cycle pulse; capture load_value.
- load_value  input  16  BCD MM:SS as {min_tens, min_units, sec_tens, sec_units}.
- num_out_0  output  4  seconds units digit.
- num_out_1  output  4  seconds tens digit.
- num_out_2  output  4  minutes units digit.
- num_out_3  output  4  minutes tens digit.
- running  output  1  high in RUNNING.
- done  output  1  high in EXPIRED.
- alarm  output  1  expiry alarm.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - Count register and reload register both = DEFAULT_VALUE.
  - running = 0, done = 0, alarm = 0; alarm counter = 0.
- Outputs are registered: num_out_0..3 show the count register directly; running and done decode from the state register.
- States and transitions:
  - IDLE: start_pause with count != 00:00 -> RUNNING. start_pause with count == 00:00 is ignored.
  - RUNNING: tick_1hz decrements the count by one second. start_pause -> PAUSED.
  - PAUSED: ticks are ignored. start_pause -> RUNNING.
  - EXPIRED: start_pause copies the reload register into the count, clears alarm, -> IDLE.
- Load:
  - load in any state: count and reload register <= sanitized load_value; state -> IDLE; alarm and alarm counter cleared.
  - Load has priority over start_pause and tick in the same cycle.
- Sanitizing: any digit > 9 is clamped to 9; seconds tens > 5 is clamped to 5.
- Decrement (BCD, borrow ripple, all within one cycle):
  - Seconds units 0 -> 9 with borrow.
  - Seconds tens 0 -> 5 with borrow.
  - Minutes units 0 -> 9 with borrow.
  - Minutes tens decrements; it never underflows because 00:00 is never decremented.
- Expiry: a decrement whose result is 00:00 -> EXPIRED on the same edge, count shows 00:00, alarm = 1, alarm counter = ALARM_TICKS.
- Alarm: in EXPIRED, each tick_1hz decrements the alarm counter. When it reaches 0, alarm = 0 on that edge. done stays 1 until leaving EXPIRED.
- Simultaneous tick_1hz and start_pause in RUNNING: the decrement is applied and state -> PAUSED. If the decrement reaches 00:00, EXPIRED wins and start_pause is dropped.
- Simultaneous tick_1hz and start_pause in PAUSED: -> RUNNING with no decrement that cycle.
- Count range: 00:00..99:59. No value outside this range is ever held.
- Latency: every input pulse takes effect on outputs at the next rising sys_clk edge.
- Reset mid-count: the count is abandoned and the outputs return immediately (asynchronously) to the reset values.

Decomposition:
- Package countdown_pkg:
  - state enum {IDLE, RUNNING, PAUSED, EXPIRED}.
  - bcd_digit_t (4-bit).
  - Constants SEC_TENS_MAX = 5 and DIGIT_MAX = 9.
  - Zero-time constant 16'h0000.
- One sub-module, bcd_digit_dec: combinational single-digit decrement.
  - Inputs: digit, borrow_in, max.
  - Outputs: digit_out, borrow_out.
  - Instantiated four times in a ripple chain.

Test Plan:
- Reset, then 3 start_pause/tick sequences: reset -> digits 0,0,1,0, done=0. start_pause, then 1 tick -> 00:59 (digits 9,5,0,0), running=1.
- Borrow ripple: load 16'h1000, start_pause, tick -> 09:59. Load 16'h0100, start_pause, tick -> 00:59.
- Expiry and alarm: load 16'h0002, start_pause, 2 ticks -> 00:00, done=1, alarm=1. With ALARM_TICKS=5, alarm=0 after the 5th further tick. Then start_pause -> count 00:02, state IDLE.
- Pause: running at 00:30, start_pause, 3 ticks -> still 00:30, running=0. start_pause and tick in the same cycle -> RUNNING, still 00:30.
- Priority and sanitize: load 16'hAB7C together with start_pause -> count 99:59 (digits 9,5,9,9), state IDLE. start_pause at 00:00 in IDLE -> stays IDLE.
- Async reset mid-run: at 00:45 RUNNING, assert rst_n=0 between clock edges -> outputs read 01:00, running=0, done=0, alarm=0 before the next edge.

Source files
------------

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types, constants and BCD sanitizer for the MM:SS countdown
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t  DIGIT_MAX    = 4'd9;
  localparam logic [15:0] ZERO_TIME    = 16'h0000;

  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input bcd_digit_t m);
    return (d > m) ? m : d;
  endfunction

  // Forces any raw word into a legal 00:00..99:59 BCD time.
  function automatic logic [15:0] sanitize_bcd(input logic [15:0] v);
    return {clamp_digit(v[15:12], DIGIT_MAX), clamp_digit(v[11:8], DIGIT_MAX),
            clamp_digit(v[7:4], SEC_TENS_MAX), clamp_digit(v[3:0], DIGIT_MAX)};
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - combinational single BCD digit decrement with borrow
module bcd_digit_dec
  import countdown_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  input  bcd_digit_t max,
  output bcd_digit_t digit_out,
  output logic       borrow_out
);

  always_comb begin
    digit_out  = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_out  = max;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_core.sv
// rtl/countdown_core.sv - MM:SS BCD countdown with start/pause, load, expiry flag and bounded alarm
module countdown_core
  import countdown_pkg::*;
#(
  parameter logic [15:0] DEFAULT_VALUE = 16'h0100,
  parameter int          ALARM_TICKS   = 5
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        start_pause,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  num_out_0,
  output logic [3:0]  num_out_1,
  output logic [3:0]  num_out_2,
  output logic [3:0]  num_out_3,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic        alarm_q, alarm_d;
  logic [7:0]  alarm_cnt_q, alarm_cnt_d;

  logic [15:0] count_dec;
  logic [4:0]  borrow;
  bcd_digit_t  digit_max [4];

  assign borrow[0]    = 1'b1;
  assign digit_max[0] = DIGIT_MAX;
  assign digit_max[1] = SEC_TENS_MAX;
  assign digit_max[2] = DIGIT_MAX;
  assign digit_max[3] = DIGIT_MAX;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (count_q[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .max        (digit_max[g]),
      .digit_out  (count_dec[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    if (load) begin
      count_d     = sanitize_bcd(load_value);
      reload_d    = sanitize_bcd(load_value);
      state_d     = IDLE;
      alarm_d     = 1'b0;
      alarm_cnt_d = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_pause && count_q != ZERO_TIME) state_d = RUNNING;
        end
        RUNNING: begin
          // A borrow out of the top digit would mean decrementing 00:00; never commit that.
          if (tick_1hz && !borrow[4]) begin
            count_d = count_dec;
            if (count_dec == ZERO_TIME) begin
              state_d     = EXPIRED;
              alarm_d     = 1'b1;
              alarm_cnt_d = 8'(ALARM_TICKS);
            end else if (start_pause) begin
              state_d = PAUSED;
            end
          end else if (start_pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (start_pause) state_d = RUNNING;
        end
        EXPIRED: begin
          if (start_pause) begin
            count_d     = reload_q;
            alarm_d     = 1'b0;
            alarm_cnt_d = 8'd0;
            state_d     = IDLE;
          end else if (tick_1hz && alarm_cnt_q != 8'd0) begin
            alarm_cnt_d = alarm_cnt_q - 8'd1;
            if (alarm_cnt_q == 8'd1) alarm_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= DEFAULT_VALUE;
      reload_q    <= DEFAULT_VALUE;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign num_out_0 = count_q[3:0];
  assign num_out_1 = count_q[7:4];
  assign num_out_2 = count_q[11:8];
  assign num_out_3 = count_q[15:12];
  assign running   = (state_q == RUNNING);
  assign done      = (state_q == EXPIRED);
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_countdown_core.sv
// tb/tb_countdown_core.sv - table-driven self-checking bench for countdown_core
module tb_countdown_core;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        start_pause = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic [3:0]  num_out_0, num_out_1, num_out_2, num_out_3;
  logic        running, done, alarm;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  countdown_core #(
    .DEFAULT_VALUE (16'h0100),
    .ALARM_TICKS   (5)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .start_pause (start_pause),
    .load        (load),
    .load_value  (load_value),
    .num_out_0   (num_out_0),
    .num_out_1   (num_out_1),
    .num_out_2   (num_out_2),
    .num_out_3   (num_out_3),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  typedef struct {
    logic        tick;
    logic        sp;
    logic        ld;
    logic [15:0] lv;
    logic [15:0] exp_cnt;
    logic        exp_run;
    logic        exp_done;
    logic        exp_alarm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic t, input logic s, input logic l, input logic [15:0] v,
                              input logic [15:0] c, input logic r, input logic d, input logic a);
    vec_t x;
    x.tick = t; x.sp = s; x.ld = l; x.lv = v;
    x.exp_cnt = c; x.exp_run = r; x.exp_done = d; x.exp_alarm = a;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [15:0] c, input logic r, input logic d,
                       input logic a);
    logic [15:0] got_cnt;
    got_cnt = {num_out_3, num_out_2, num_out_1, num_out_0};
    checks++;
    if (got_cnt !== c || running !== r || done !== d || alarm !== a) begin
      failures++;
      $display("FAIL %s: got cnt=%h run=%b done=%b alarm=%b, expected cnt=%h run=%b done=%b alarm=%b",
               name, got_cnt, running, done, alarm, c, r, d, a);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic l, input logic [15:0] v);
    @(negedge sys_clk);
    tick_1hz = t; start_pause = s; load = l; load_value = v;
    @(posedge sys_clk);
    #1;
    tick_1hz = 1'b0; start_pause = 1'b0; load = 1'b0; load_value = 16'h0000;
  endtask

  initial begin
    // tick, sp, load, load_value, expected count, running, done, alarm
    add(0,0,0,16'h0000, 16'h0100, 0,0,0);
    add(0,1,0,16'h0000, 16'h0100, 1,0,0);
    add(1,0,0,16'h0000, 16'h0059, 1,0,0);
    add(0,0,1,16'h1000, 16'h1000, 0,0,0);
    add(0,1,0,16'h0000, 16'h1000, 1,0,0);
    add(1,0,0,16'h0000, 16'h0959, 1,0,0);
    add(0,0,1,16'h0100, 16'h0100, 0,0,0);
    add(0,1,0,16'h0000, 16'h0100, 1,0,0);
    add(1,0,0,16'h0000, 16'h0059, 1,0,0);
    add(0,0,1,16'h0002, 16'h0002, 0,0,0);
    add(0,1,0,16'h0000, 16'h0002, 1,0,0);
    add(1,0,0,16'h0000, 16'h0001, 1,0,0);
    add(1,0,0,16'h0000, 16'h0000, 0,1,1);
    add(1,0,0,16'h0000, 16'h0000, 0,1,1);
    add(1,0,0,16'h0000, 16'h0000, 0,1,1);
    add(1,0,0,16'h0000, 16'h0000, 0,1,1);
    add(1,0,0,16'h0000, 16'h0000, 0,1,1);
    add(1,0,0,16'h0000, 16'h0000, 0,1,0);
    add(1,0,0,16'h0000, 16'h0000, 0,1,0);
    add(0,1,0,16'h0000, 16'h0002, 0,0,0);
    add(0,0,1,16'h0031, 16'h0031, 0,0,0);
    add(0,1,0,16'h0000, 16'h0031, 1,0,0);
    add(1,0,0,16'h0000, 16'h0030, 1,0,0);
    add(0,1,0,16'h0000, 16'h0030, 0,0,0);
    add(1,0,0,16'h0000, 16'h0030, 0,0,0);
    add(1,0,0,16'h0000, 16'h0030, 0,0,0);
    add(1,0,0,16'h0000, 16'h0030, 0,0,0);
    add(1,1,0,16'h0000, 16'h0030, 1,0,0);
    add(1,0,0,16'h0000, 16'h0029, 1,0,0);
    add(1,1,0,16'h0000, 16'h0028, 0,0,0);
    add(1,1,1,16'hAB7C, 16'h9959, 0,0,0);
    add(1,0,0,16'h0000, 16'h9959, 0,0,0);
    add(0,0,1,16'h0000, 16'h0000, 0,0,0);
    add(0,1,0,16'h0000, 16'h0000, 0,0,0);
    add(1,0,0,16'h0000, 16'h0000, 0,0,0);
    add(0,0,1,16'h0001, 16'h0001, 0,0,0);
    add(0,1,0,16'h0000, 16'h0001, 1,0,0);
    add(1,1,0,16'h0000, 16'h0000, 0,1,1);
    add(1,1,0,16'h0000, 16'h0001, 0,0,0);
    add(0,1,0,16'h0000, 16'h0001, 1,0,0);
    add(1,0,0,16'h0000, 16'h0000, 0,1,1);
    add(0,0,1,16'h0500, 16'h0500, 0,0,0);
    add(1,0,0,16'h0000, 16'h0500, 0,0,0);

    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_state", 16'h0100, 0, 0, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].tick, vecs[i].sp, vecs[i].ld, vecs[i].lv);
      check($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_run, vecs[i].exp_done,
            vecs[i].exp_alarm);
    end

    // Asynchronous reset while running at 00:45: outputs must clear before the next edge.
    step(0,0,1,16'h0046);
    step(0,1,0,16'h0000);
    step(1,0,0,16'h0000);
    check("pre_async_reset", 16'h0045, 1, 0, 0);
    @(negedge sys_clk);
    #1 rst_n = 1'b0;
    #2;
    check("async_reset_running", 16'h0100, 0, 0, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Same again from EXPIRED with alarm active.
    step(0,0,1,16'h0001);
    step(0,1,0,16'h0000);
    step(1,0,0,16'h0000);
    check("pre_async_reset_expired", 16'h0000, 0, 1, 1);
    @(negedge sys_clk);
    #1 rst_n = 1'b0;
    #2;
    check("async_reset_expired", 16'h0100, 0, 0, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    step(0,1,0,16'h0000);
    check("restart_after_reset", 16'h0100, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
